// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the ID/EX pipeline logic and the hazard controller.
// The pipeline drives the ID/EX fields; the controller returns the stall/flush/MD controls.
interface hazard_ctrl_if;
  logic [4:0] ID_rs;
  logic [4:0] ID_rt;
  logic       ID_UseRs;
  logic       ID_UseRt;
  logic       ID_MdStart;
  logic       ID_MdIsDiv;
  logic       ID_MdRead;
  logic       ID_Jump;
  logic       EX_MemRd;
  logic [4:0] EX_WrReg;
  logic       EX_BrTaken;
  logic       stall;
  logic       PC_Wr;
  logic       IFID_Wr;
  logic       IFID_Flush;
  logic       MD_Busy;
  logic       MD_Done;

  modport master (
    output ID_rs, ID_rt, ID_UseRs, ID_UseRt, ID_MdStart, ID_MdIsDiv, ID_MdRead, ID_Jump,
    output EX_MemRd, EX_WrReg, EX_BrTaken,
    input  stall, PC_Wr, IFID_Wr, IFID_Flush, MD_Busy, MD_Done
  );

  modport slave (
    input  ID_rs, ID_rt, ID_UseRs, ID_UseRt, ID_MdStart, ID_MdIsDiv, ID_MdRead, ID_Jump,
    input  EX_MemRd, EX_WrReg, EX_BrTaken,
    output stall, PC_Wr, IFID_Wr, IFID_Flush, MD_Busy, MD_Done
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and mult/div occupancy stalls, branch/jump redirects.
// The only state is the MD occupancy FSM with its busy countdown.
module hazard_ctrl #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic        clk,
  input  logic        reset,
  hazard_ctrl_if.slave bus
);

  typedef enum logic {IDLE, RUN} md_st_t;

  md_st_t           r_st;
  logic [CNT_W-1:0] r_cnt;
  md_st_t           w_st_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic w_lu;
  logic w_last;
  logic w_md;

  always_comb begin
    w_lu = bus.EX_MemRd && (bus.EX_WrReg != 5'd0) &&
           ((bus.ID_UseRs && (bus.ID_rs == bus.EX_WrReg)) ||
            (bus.ID_UseRt && (bus.ID_rt == bus.EX_WrReg)));
    w_last = (r_st == RUN) && (r_cnt == CNT_W'(1));
    // mfhi/mflo in the final busy cycle gets the forwarded result, so it is not held
    w_md = (r_st == RUN) && (bus.ID_MdStart || bus.ID_MdRead) &&
           !(w_last && bus.ID_MdRead && !bus.ID_MdStart);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_st  <= IDLE;
      r_cnt <= '0;
    end else begin
      r_st  <= w_st_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_st_nxt  = r_st;
    w_cnt_nxt = r_cnt;
    unique case (r_st)
      IDLE: begin
        if (bus.ID_MdStart && !bus.EX_BrTaken && !w_lu) begin
          w_st_nxt  = RUN;
          w_cnt_nxt = bus.ID_MdIsDiv ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
        end
      end
      RUN: begin
        if (w_last) begin
          w_st_nxt  = IDLE;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_st_nxt  = IDLE;
        w_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    bus.stall      = 1'b0;
    bus.PC_Wr      = 1'b1;
    bus.IFID_Wr    = 1'b1;
    bus.IFID_Flush = 1'b0;
    bus.MD_Busy    = (r_st == RUN);
    bus.MD_Done    = w_last;
    if (reset) begin
      bus.stall      = 1'b1;
      bus.PC_Wr      = 1'b0;
      bus.IFID_Wr    = 1'b0;
      bus.IFID_Flush = 1'b1;
      bus.MD_Busy    = 1'b0;
      bus.MD_Done    = 1'b0;
    end else if (bus.EX_BrTaken) begin
      bus.stall      = 1'b1;
      bus.IFID_Flush = 1'b1;
    end else if (w_lu || w_md) begin
      bus.stall      = 1'b1;
      bus.PC_Wr      = 1'b0;
      bus.IFID_Wr    = 1'b0;
    end else if (bus.ID_Jump) begin
      bus.IFID_Flush = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-count reference model of the MD unit and priority rules.
module tb_hazard_ctrl;

  logic clk;
  logic reset;
  int unsigned errors;
  int unsigned checks;

  hazard_ctrl_if bus ();

  hazard_ctrl #(
    .MUL_CYCLES(4),
    .DIV_CYCLES(32),
    .CNT_W(6)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: remaining busy cycles of the MD unit (0 = free).
  int   rem;
  logic [5:0] exp_v;
  logic [5:0] act_v;

  function automatic logic model_lu();
    return bus.EX_MemRd && (bus.EX_WrReg != 5'd0) &&
           ((bus.ID_UseRs && bus.ID_rs == bus.EX_WrReg) ||
            (bus.ID_UseRt && bus.ID_rt == bus.EX_WrReg));
  endfunction

  function automatic logic [5:0] model_out();
    logic md;
    logic [3:0] ctl;
    if (reset) return 6'b100100;
    md = (rem > 0) && (bus.ID_MdStart || bus.ID_MdRead) &&
         !(rem == 1 && bus.ID_MdRead && !bus.ID_MdStart);
    if (bus.EX_BrTaken)          ctl = 4'b1111;
    else if (model_lu() || md)   ctl = 4'b1000;
    else if (bus.ID_Jump)        ctl = 4'b0111;
    else                         ctl = 4'b0110;
    return {ctl, rem > 0, rem == 1};
  endfunction

  // Called just after a negedge with inputs applied; returns just after the next negedge.
  task automatic tick();
    #1;
    if (reset) rem = 0;
    exp_v = model_out();
    act_v = {bus.stall, bus.PC_Wr, bus.IFID_Wr, bus.IFID_Flush, bus.MD_Busy, bus.MD_Done};
    @(posedge clk);
    if (reset) rem = 0;
    else if (rem > 0) rem = rem - 1;
    else if (bus.ID_MdStart && !bus.EX_BrTaken && !model_lu())
      rem = bus.ID_MdIsDiv ? 32 : 4;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.ID_rs = '0; bus.ID_rt = '0; bus.ID_UseRs = 0; bus.ID_UseRt = 0;
    bus.ID_MdStart = 0; bus.ID_MdIsDiv = 0; bus.ID_MdRead = 0; bus.ID_Jump = 0;
    bus.EX_MemRd = 0; bus.EX_WrReg = '0; bus.EX_BrTaken = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    checks++;
    if (act_v !== 6'b100100) begin
      errors++; $display("FAIL reset_outputs got=%b exp=%b", act_v, 6'b100100);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (act_v !== 6'b011000) begin
      errors++; $display("FAIL after_reset got=%b exp=%b", act_v, 6'b011000);
    end
  endtask

  task automatic test_load_use();
    idle_inputs();
    bus.EX_MemRd = 1; bus.EX_WrReg = 5'd8; bus.ID_rs = 5'd8; bus.ID_UseRs = 1;
    tick();
    checks++;
    if (act_v !== 6'b100000) begin
      errors++; $display("FAIL load_use_stall got=%b exp=%b", act_v, 6'b100000);
    end
    bus.EX_MemRd = 0;
    tick();
    checks++;
    if (act_v !== 6'b011000) begin
      errors++; $display("FAIL load_use_release got=%b exp=%b", act_v, 6'b011000);
    end
    bus.EX_MemRd = 1; bus.EX_WrReg = 5'd0; bus.ID_rs = 5'd0;
    tick();
    checks++;
    if (act_v !== 6'b011000) begin
      errors++; $display("FAIL load_use_r0 got=%b exp=%b", act_v, 6'b011000);
    end
    bus.EX_WrReg = 5'd9; bus.ID_rs = 5'd3; bus.ID_UseRs = 1; bus.ID_rt = 5'd9; bus.ID_UseRt = 1;
    tick();
    checks++;
    if (act_v !== 6'b100000) begin
      errors++; $display("FAIL load_use_rt got=%b exp=%b", act_v, 6'b100000);
    end
    idle_inputs();
  endtask

  task automatic test_mult();
    logic [5:0] want;
    idle_inputs();
    bus.ID_MdStart = 1;
    tick();
    checks++;
    if (act_v !== 6'b011000) begin
      errors++; $display("FAIL mult_issue got=%b exp=%b", act_v, 6'b011000);
    end
    bus.ID_MdStart = 0; bus.ID_MdRead = 1;
    for (int i = 1; i <= 4; i++) begin
      want = (i < 4) ? 6'b100010 : 6'b011011;
      tick();
      checks++;
      if (act_v !== want) begin
        errors++; $display("FAIL mult_busy_cycle%0d got=%b exp=%b", i, act_v, want);
      end
    end
    tick();
    checks++;
    if (act_v !== 6'b011000) begin
      errors++; $display("FAIL mult_done_idle got=%b exp=%b", act_v, 6'b011000);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [5:0] want;
    idle_inputs();
    bus.ID_MdStart = 1; bus.ID_MdIsDiv = 1;
    tick();
    checks++;
    if (act_v !== 6'b011000) begin
      errors++; $display("FAIL div_issue got=%b exp=%b", act_v, 6'b011000);
    end
    for (int i = 1; i <= 32; i++) begin
      want = (i < 32) ? 6'b100010 : 6'b100011;
      tick();
      checks++;
      if (act_v !== want) begin
        errors++; $display("FAIL div_second_start_cycle%0d got=%b exp=%b", i, act_v, want);
      end
    end
    tick();
    checks++;
    if (act_v !== 6'b011000) begin
      errors++; $display("FAIL div_second_issue got=%b exp=%b", act_v, 6'b011000);
    end
    bus.ID_MdStart = 0; bus.ID_MdIsDiv = 0;
    for (int i = 0; i < 33; i++) begin
      tick();
      checks++;
      if (act_v !== exp_v) begin
        errors++; $display("FAIL div_drain_cycle%0d got=%b exp=%b", i, act_v, exp_v);
      end
    end
    idle_inputs();
  endtask

  task automatic test_branch();
    idle_inputs();
    bus.EX_BrTaken = 1; bus.EX_MemRd = 1; bus.EX_WrReg = 5'd8; bus.ID_rs = 5'd8;
    bus.ID_UseRs = 1; bus.ID_MdStart = 1;
    tick();
    checks++;
    if (act_v !== 6'b111100) begin
      errors++; $display("FAIL branch_priority got=%b exp=%b", act_v, 6'b111100);
    end
    idle_inputs();
    tick();
    checks++;
    if (act_v !== 6'b011000) begin
      errors++; $display("FAIL branch_squash_md got=%b exp=%b", act_v, 6'b011000);
    end
  endtask

  task automatic test_jump_lu();
    idle_inputs();
    bus.ID_Jump = 1; bus.EX_MemRd = 1; bus.EX_WrReg = 5'd5; bus.ID_rt = 5'd5; bus.ID_UseRt = 1;
    tick();
    checks++;
    if (act_v !== 6'b100000) begin
      errors++; $display("FAIL jump_lu_stall got=%b exp=%b", act_v, 6'b100000);
    end
    bus.EX_MemRd = 0;
    tick();
    checks++;
    if (act_v !== 6'b011100) begin
      errors++; $display("FAIL jump_after_lu got=%b exp=%b", act_v, 6'b011100);
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    idle_inputs();
    bus.ID_MdStart = 1; bus.ID_MdIsDiv = 1;
    tick();
    idle_inputs();
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (rem != 17 || act_v[1] !== 1'b1) begin
      errors++; $display("FAIL async_setup_busy got=%b rem=%0d exp busy=1 rem=17", act_v[1], rem);
    end
    reset = 1'b1;
    #1;
    act_v = {bus.stall, bus.PC_Wr, bus.IFID_Wr, bus.IFID_Flush, bus.MD_Busy, bus.MD_Done};
    checks++;
    if (act_v !== 6'b100100) begin
      errors++; $display("FAIL async_reset_immediate got=%b exp=%b", act_v, 6'b100100);
    end
    rem = 0;
    @(negedge clk);
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (act_v !== 6'b011000) begin
      errors++; $display("FAIL async_reset_release got=%b exp=%b", act_v, 6'b011000);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset          = ($urandom_range(0, 79) == 0);
      bus.ID_rs      = 5'($urandom_range(0, 3));
      bus.ID_rt      = 5'($urandom_range(0, 3));
      bus.ID_UseRs   = 1'($urandom);
      bus.ID_UseRt   = 1'($urandom);
      bus.ID_MdStart = ($urandom_range(0, 5) == 0);
      bus.ID_MdIsDiv = ($urandom_range(0, 3) == 0);
      bus.ID_MdRead  = ($urandom_range(0, 2) == 0);
      bus.ID_Jump    = ($urandom_range(0, 5) == 0);
      bus.EX_MemRd   = ($urandom_range(0, 2) == 0);
      bus.EX_WrReg   = 5'($urandom_range(0, 3));
      bus.EX_BrTaken = ($urandom_range(0, 7) == 0);
      tick();
      checks++;
      if (act_v !== exp_v) begin
        errors++; $display("FAIL random_cycle%0d got=%b exp=%b rem=%0d", i, act_v, exp_v, rem);
      end
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rem    = 0;
    reset  = 1'b1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_mult();
    test_back_to_back();
    test_branch();
    test_jump_lu();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
